// File: rtl/coef_ram_pkg.sv
// Shared types, sizes and helpers for the ping-pong coefficient store.
package coef_ram_pkg;

  localparam int COEF_W  = 12;
  localparam int COEF_AW = 8;

  // Bank identifier used by the fill/drain selectors.
  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  // Read latency in clock cycles for a given output-register setting.
  function automatic int rd_lat(input int out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/coef_pingpong_bram_if.sv
// Producer/consumer bus of the ping-pong coefficient store.
interface coef_pingpong_bram_if
  import coef_ram_pkg::*;
#(
  parameter int DW = COEF_W,
  parameter int AW = COEF_AW
);
  // producer side
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic          wr_last;
  logic          wr_ready;
  // consumer side
  logic          ren;
  logic [AW-1:0] raddr;
  logic          rd_last;
  logic          rd_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  // status
  logic [1:0]    full_cnt;
  logic          err;

  // Producer + consumer view (drives strobes, observes status and data).
  modport master (
    output wen, waddr, din, wr_last, ren, raddr, rd_last,
    input  wr_ready, rd_ready, dout, dout_valid, full_cnt, err
  );

  // Store view.
  modport slave (
    input  wen, waddr, din, wr_last, ren, raddr, rd_last,
    output wr_ready, rd_ready, dout, dout_valid, full_cnt, err
  );

endinterface

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port,
// optional second output register. Read registers hold between reads.
module sdp_bram #(
  parameter int DW      = 12,
  parameter int AW      = 8,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  (* ram_style = "block" *) logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  // Write port; array contents are never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read; the output latch has a synchronous reset and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= mem_q[raddr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          re_q;
      logic [DW-1:0] oreg_q;

      // Second output stage, loaded one cycle after the array read.
      always_ff @(posedge clk) begin
        if (rst) begin
          re_q   <= 1'b0;
          oreg_q <= '0;
        end else begin
          re_q <= re;
          if (re_q) begin
            oreg_q <= rd_q;
          end
        end
      end

      assign rdata = oreg_q;
    end else begin : g_noreg
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/coef_pingpong_bram.sv
// Double-buffered coefficient store: the producer fills one bank while the
// consumer drains the other; banks change hands on wr_last / rd_last.
module coef_pingpong_bram
  import coef_ram_pkg::*;
#(
  parameter int DW      = COEF_W,
  parameter int AW      = COEF_AW,
  parameter int OUT_REG = 0
) (
  input logic                 clk,
  input logic                 rst,
  coef_pingpong_bram_if.slave bus
);

  localparam int LAT = rd_lat(OUT_REG);

  bank_e      wr_sel_q, wr_sel_d;
  bank_e      rd_sel_q, rd_sel_d;
  logic [1:0] full_q, full_d;
  logic       err_q, err_d;

  logic       wr_ready, rd_ready;
  logic       wr_acc, rd_acc;
  logic       wr_last_acc, rd_last_acc;

  logic [1:0] wr_oh, rd_oh;
  logic [1:0] bank_we, bank_re;
  logic [DW-1:0] bank_rdata [2];

  // Per-stage read-valid flag and the bank that stage read from.
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] sel_pipe_q;

  // Handshake decode and next state of the bank selectors / full flags.
  always_comb begin
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    err_d       = err_q;

    wr_ready    = !full_q[wr_sel_q];
    rd_ready    = full_q[rd_sel_q];
    wr_acc      = bus.wen & wr_ready;
    rd_acc      = bus.ren & rd_ready;
    wr_last_acc = bus.wr_last & wr_ready;
    rd_last_acc = bus.rd_last & rd_ready;

    // A filling bank is empty and a draining bank is full, so when both
    // last strobes are accepted they always hit different banks.
    if (wr_last_acc) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = bank_e'(~wr_sel_q);
    end
    if (rd_last_acc) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = bank_e'(~rd_sel_q);
    end

    if ((bus.wen & !wr_ready) | (bus.wr_last & !wr_ready) | (bus.ren & !rd_ready)) begin
      err_d = 1'b1;
    end
  end

  // Selector, full-flag and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q <= BANK0;
      rd_sel_q <= BANK0;
      full_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  // Steer the accepted strobes to the selected bank; nothing is written in a reset cycle.
  always_comb begin
    wr_oh   = {wr_sel_q == BANK1, wr_sel_q == BANK0};
    rd_oh   = {rd_sel_q == BANK1, rd_sel_q == BANK0};
    bank_we = {2{wr_acc & !rst}} & wr_oh;
    bank_re = {2{rd_acc & !rst}} & rd_oh;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      sdp_bram #(
        .DW      (DW),
        .AW      (AW),
        .OUT_REG (OUT_REG)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we[gi]),
        .waddr (bus.waddr),
        .wdata (bus.din),
        .re    (bank_re[gi]),
        .raddr (bus.raddr),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Valid shift register tracking in-flight reads; reset flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      sel_pipe_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        sel_pipe_q[0] <= rd_sel_q;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          sel_pipe_q[i] <= sel_pipe_q[i-1];
        end
      end
    end
  end

  // The last-stage select only moves with a completing read, so dout holds
  // the most recent result (both bank outputs hold between their reads).
  assign bus.dout       = sel_pipe_q[LAT-1] ? bank_rdata[1] : bank_rdata[0];
  assign bus.dout_valid = vld_q[LAT-1];
  assign bus.wr_ready   = wr_ready;
  assign bus.rd_ready   = rd_ready;
  assign bus.full_cnt   = 2'(full_q[0]) + 2'(full_q[1]);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_coef_pingpong_bram.sv
// Self-checking bench for coef_pingpong_bram (OUT_REG=1, read latency 2).
module tb_coef_pingpong_bram;
  import coef_ram_pkg::*;

  localparam int DW      = 12;
  localparam int AW      = 8;
  localparam int OUT_REG = 1;
  localparam int LAT     = 1 + OUT_REG;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  coef_pingpong_bram_if #(.DW(DW), .AW(AW)) bus ();

  coef_pingpong_bram #(
    .DW      (DW),
    .AW      (AW),
    .OUT_REG (OUT_REG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    bit rst;
    bit wen;
    bit wr_last;
    bit ren;
    bit rd_last;
    int addr;
    int din;
    bit push;
    int edata;
    bit e_wr_ready;
    bit e_rd_ready;
    int e_cnt;
    bit e_err;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of stimulus; an expected read result is queued when the
  // read should be accepted. Returns on the following falling edge.
  task automatic step(input bit w, input int wa, input int d, input bit wl,
                      input bit r, input int ra, input bit rl,
                      input bit push, input int edata);
    exp_t e;
    bus.wen     = w;
    bus.waddr   = AW'(wa);
    bus.din     = DW'(d);
    bus.wr_last = wl;
    bus.ren     = r;
    bus.raddr   = AW'(ra);
    bus.rd_last = rl;
    if (push) begin
      e.data = DW'(edata);
      e.due  = cyc + LAT;
      sb_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int wr, input int rd, input int cnt, input int er);
    chk({tag, "_wr_ready"}, int'(bus.wr_ready), wr);
    chk({tag, "_rd_ready"}, int'(bus.rd_ready), rd);
    chk({tag, "_full_cnt"}, int'(bus.full_cnt), cnt);
    chk({tag, "_err"},      int'(bus.err),      er);
  endtask

  // Scoreboard: every dout_valid pulse must match the oldest queued read,
  // both in data and in the cycle it arrives.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dout_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("dout", int'(bus.dout), int'(e.data));
        chk("read_latency_cycle", cyc, e.due);
        $display("[cyc %0d] read completed dout=%0d expected=%0d", cyc, bus.dout, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vec[14];

  initial begin
    // rst wen wl ren rl addr din push edata | wr rd cnt err
    vec[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 1}; // underflow read
    vec[2]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0};
    vec[3]  = '{0, 1, 0, 0, 0, 3, 33, 0, 0,  1, 0, 0, 0};
    vec[4]  = '{0, 1, 1, 0, 0, 4, 44, 0, 0,  1, 1, 1, 0}; // bank0 full
    vec[5]  = '{0, 1, 1, 0, 0, 3, 55, 0, 0,  0, 1, 2, 0}; // bank1 full
    vec[6]  = '{0, 1, 1, 0, 0, 3, 66, 0, 0,  0, 1, 2, 1}; // overflow, dropped
    vec[7]  = '{0, 0, 0, 1, 0, 3, 0,  1, 33, 0, 1, 2, 1};
    vec[8]  = '{0, 0, 0, 1, 1, 4, 0,  1, 44, 1, 1, 1, 1};
    vec[9]  = '{0, 0, 0, 1, 1, 3, 0,  1, 55, 1, 0, 0, 1};
    vec[10] = '{0, 1, 1, 0, 0, 9, 99, 0, 0,  1, 1, 1, 1};
    vec[11] = '{0, 0, 0, 1, 1, 3, 0,  1, 33, 1, 0, 0, 1}; // 66 was never stored
    vec[12] = '{0, 0, 0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 1};
    vec[13] = '{1, 0, 0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0};

    bus.wen = 0; bus.waddr = '0; bus.din = '0; bus.wr_last = 0;
    bus.ren = 0; bus.raddr = '0; bus.rd_last = 0;
    @(negedge clk);

    // 1: reset state
    do_reset();
    chk_status("reset", 1, 0, 0, 0);
    chk("reset_dout_valid", int'(bus.dout_valid), 0);
    chk("reset_dout", int'(bus.dout), 0);

    // 2: first fill of bank0, then a single read
    for (int a = 0; a < 256; a++) begin
      step(1, a, a, a == 255, 0, 0, 0, 0, 0);
      if (a == 254) chk_status("fill0_before_last", 1, 0, 0, 0);
    end
    chk_status("fill0_done", 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 7, 0, 1, 7);
    chk("first_read_not_early", int'(bus.dout_valid), 0);
    idle(1);
    idle(2);
    chk("dout_hold", int'(bus.dout), 7);
    chk("dout_valid_idle", int'(bus.dout_valid), 0);

    // 3: fill bank1 while draining bank0, both last strobes together
    for (int a = 0; a < 256; a++) begin
      step(1, a, a + 1000, a == 255, 1, a, a == 255, 1, a);
      chk("pingpong_full_cnt", int'(bus.full_cnt), 1);
      chk("pingpong_rd_ready", int'(bus.rd_ready), 1);
      chk("pingpong_wr_ready", int'(bus.wr_ready), 1);
    end
    step(0, 0, 0, 0, 1, 7, 0, 1, 1007);
    idle(LAT);

    // 4: both banks full, overflow write must not land
    for (int a = 0; a < 256; a++) step(1, a, a + 2000, a == 255, 0, 0, 0, 0, 0);
    chk_status("both_full", 0, 1, 2, 0);
    step(1, 7, 999, 0, 0, 0, 0, 0, 0);
    chk_status("overflow", 0, 1, 2, 1);
    for (int a = 0; a < 256; a++) step(0, 0, 0, 0, 1, a, a == 255, 1, a + 1000);
    for (int a = 0; a < 256; a++) step(0, 0, 0, 0, 1, a, a == 255, 1, a + 2000);
    idle(LAT);
    chk_status("drained", 1, 0, 0, 1);

    // 5: table of short protocol vectors (includes underflow)
    for (int i = 0; i < 14; i++) begin
      rst = vec[i].rst;
      step(vec[i].wen, vec[i].addr, vec[i].din, vec[i].wr_last,
           vec[i].ren, vec[i].addr, vec[i].rd_last, vec[i].push, vec[i].edata);
      rst = 1'b0;
      chk_status($sformatf("vec%0d", i), vec[i].e_wr_ready, vec[i].e_rd_ready,
                 vec[i].e_cnt, vec[i].e_err);
    end

    // 6: reset while a read is in flight; writes in the reset cycle are ignored
    step(1, 7, 77, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0, 0);   // accepted, but flushed by the reset below
    rst = 1'b1;
    step(1, 7, 55, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("midrst_dout_valid", int'(bus.dout_valid), 0);
    chk_status("midrst", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("midrst_no_valid", int'(bus.dout_valid), 0);
    end
    step(1, 8, 88, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 1, 77);
    step(0, 0, 0, 0, 1, 8, 1, 1, 88);
    idle(LAT + 1);
    chk_status("after_midrst", 1, 0, 0, 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
